// File: rtl/bp_be_pkg.sv
// Backend shared types: CSR op encodings and the system command bundle.
// The command struct is declared per-instance because its widths are parametric.
`define DECLARE_BP_BE_SYS_CMD_S(op_w, data_w) \
    typedef struct packed { \
        logic [(op_w)-1:0]   op; \
        logic [11:0]         addr; \
        logic [(data_w)-1:0] data; \
    } bp_be_sys_cmd_s

`define BP_BE_SYS_CMD_WIDTH(op_w, data_w) ((op_w) + 12 + (data_w))

package bp_be_pkg;

    localparam int csr_addr_width_gp = 12;

    typedef enum logic [4:0] {
        e_csrrw  = 5'h00,
        e_csrrs  = 5'h01,
        e_csrrc  = 5'h02,
        e_csrrwi = 5'h03,
        e_csrrsi = 5'h04,
        e_csrrci = 5'h05,
        e_ecall  = 5'h06,
        e_ebreak = 5'h07,
        e_mret   = 5'h08,
        e_sret   = 5'h09,
        e_wfi    = 5'h0a,
        e_sfence = 5'h0b
    } bp_be_csr_fu_op_e;

endpackage

// File: rtl/bp_be_sys_cmd_fifo.sv
// 1r1w command FIFO with occupancy count; accepts an enqueue when full
// provided the head leaves in the same cycle.
module bp_be_sys_cmd_fifo
    import bp_be_pkg::*;
#(
    parameter int width_p = 81,
    parameter int els_p   = 4
)
(
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [width_p-1:0]         data_i,
    input  logic                       yumi_i,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    output logic                       full_o,
    output logic [$clog2(els_p+1)-1:0] count_o
);

    localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_width_lp = $clog2(els_p + 1);

    logic [width_p-1:0]      mem [els_p];
    logic [ptr_width_lp-1:0] wptr;
    logic [ptr_width_lp-1:0] rptr;
    logic [cnt_width_lp-1:0] count;
    logic                    enq;
    logic                    deq;

    function automatic logic [ptr_width_lp-1:0] bump(
        input logic [ptr_width_lp-1:0] p
    );
        return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign v_o     = (count != '0);
    assign full_o  = (count == cnt_width_lp'(els_p));
    assign count_o = count;
    assign data_o  = mem[rptr];
    assign deq     = yumi_i & v_o;
    assign enq     = v_i & (~full_o | deq);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < els_p; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (enq) begin
                mem[wptr] <= data_i;
                wptr      <= bump(wptr);
            end
            if (deq) begin
                rptr <= bump(rptr);
            end
            unique case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bp_be_sys_cmd_queue.sv
// Killable CSR command pipe with prioritised fault/fill merge at the tail,
// buffered into a FIFO drained by the CSR unit.
module bp_be_sys_cmd_queue
    import bp_be_pkg::*;
#(
    parameter int data_width_p   = 64,
    parameter int vaddr_width_p  = 39,
    parameter int csr_op_width_p = 5,
    parameter int stages_p       = 2,
    parameter int num_fault_p    = 8,
    parameter int fifo_els_p     = 4
)
(
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  cmd_v_i,
    input  logic [csr_op_width_p-1:0]             cmd_op_i,
    input  logic [csr_addr_width_gp-1:0]          cmd_addr_i,
    input  logic [data_width_p-1:0]               cmd_data_i,
    input  logic [stages_p-1:0]                   kill_i,
    input  logic [num_fault_p-1:0]                fault_v_i,
    input  logic [num_fault_p*csr_op_width_p-1:0] fault_op_i,
    input  logic [vaddr_width_p-1:0]              fault_vaddr_i,
    output logic                                  csr_cmd_v_o,
    output logic [csr_op_width_p-1:0]             csr_cmd_op_o,
    output logic [csr_addr_width_gp-1:0]          csr_cmd_addr_o,
    output logic [data_width_p-1:0]               csr_cmd_data_o,
    input  logic                                  csr_cmd_ready_i,
    output logic                                  stall_o,
    output logic                                  overflow_o
);

    `DECLARE_BP_BE_SYS_CMD_S(csr_op_width_p, data_width_p);

    localparam int cmd_width_lp =
        `BP_BE_SYS_CMD_WIDTH(csr_op_width_p, data_width_p);
    localparam int cnt_width_lp = $clog2(fifo_els_p + 1);

    logic [stages_p-1:0]       stage_v_r;
    bp_be_sys_cmd_s            stage_r [stages_p];
    logic                      head_v;
    bp_be_sys_cmd_s            head;
    logic                      fault_any;
    logic [csr_op_width_p-1:0] fault_op;
    bp_be_sys_cmd_s            enq_cmd;
    logic                      enq_v;
    logic                      deq;
    logic                      fifo_full;
    logic [cnt_width_lp-1:0]   count;
    logic [cmd_width_lp-1:0]   fifo_data;
    bp_be_sys_cmd_s            out_cmd;
    logic                      overflow_r;
    logic [31:0]               occupancy;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            stage_v_r <= '0;
            for (int s = 0; s < stages_p; s++) begin
                stage_r[s] <= '0;
            end
        end else begin
            stage_v_r[0]    <= cmd_v_i;
            stage_r[0].op   <= cmd_op_i;
            stage_r[0].addr <= cmd_addr_i;
            stage_r[0].data <= cmd_data_i;
            // a kill on stage s squashes the entry as it leaves that stage
            for (int s = 1; s < stages_p; s++) begin
                stage_v_r[s] <= stage_v_r[s-1] & ~kill_i[s-1];
                stage_r[s]   <= stage_r[s-1];
            end
        end
    end

    assign head_v = stage_v_r[stages_p-1];
    assign head   = stage_r[stages_p-1];

    // descending scan so the lowest requesting source is the last to win
    always_comb begin
        fault_any = 1'b0;
        fault_op  = '0;
        for (int k = num_fault_p - 1; k >= 0; k--) begin
            if (fault_v_i[k]) begin
                fault_any = 1'b1;
                fault_op  = fault_op_i[k*csr_op_width_p +: csr_op_width_p];
            end
        end
    end

    always_comb begin
        enq_cmd = head;
        if (fault_any) begin
            enq_cmd.op   = fault_op;
            enq_cmd.addr = head_v ? head.addr : '0;
            enq_cmd.data = data_width_p'(fault_vaddr_i);
        end
    end

    assign enq_v = fault_any | (head_v & ~kill_i[stages_p-1]);
    assign deq   = csr_cmd_v_o & csr_cmd_ready_i;

    bp_be_sys_cmd_fifo #(
        .width_p (cmd_width_lp),
        .els_p   (fifo_els_p)
    ) fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (enq_v),
        .data_i    (enq_cmd),
        .yumi_i    (deq),
        .v_o       (csr_cmd_v_o),
        .data_o    (fifo_data),
        .full_o    (fifo_full),
        .count_o   (count)
    );

    assign out_cmd        = fifo_data;
    assign csr_cmd_op_o   = out_cmd.op;
    assign csr_cmd_addr_o = out_cmd.addr;
    assign csr_cmd_data_o = out_cmd.data;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            overflow_r <= 1'b0;
        end else if (enq_v & fifo_full & ~deq) begin
            overflow_r <= 1'b1;
        end
    end

    assign overflow_o = overflow_r;

    // reserve a slot for every command already in flight
    always_comb begin
        occupancy = 32'(count);
        for (int s = 0; s < stages_p; s++) begin
            occupancy = occupancy + 32'(stage_v_r[s]);
        end
    end

    assign stall_o = (occupancy >= 32'(fifo_els_p));

endmodule

// File: tb/tb_bp_be_sys_cmd_queue.sv
// Scoreboard bench for bp_be_sys_cmd_queue: directed cases followed by
// randomized traffic against a transaction-level reference model.
module tb_bp_be_sys_cmd_queue;

    localparam int S  = 2;
    localparam int NF = 8;
    localparam int OW = 5;
    localparam int DW = 64;
    localparam int VW = 39;
    localparam int FE = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            cmd_v;
    logic [OW-1:0]   cmd_op;
    logic [11:0]     cmd_addr;
    logic [DW-1:0]   cmd_data;
    logic [S-1:0]    kill;
    logic [NF-1:0]   fault_v;
    logic [NF*OW-1:0] fault_op;
    logic [VW-1:0]   fault_vaddr;
    logic            csr_cmd_v;
    logic [OW-1:0]   csr_cmd_op;
    logic [11:0]     csr_cmd_addr;
    logic [DW-1:0]   csr_cmd_data;
    logic            csr_cmd_ready;
    logic            stall;
    logic            overflow;

    always #5 clk = ~clk;

    bp_be_sys_cmd_queue #(
        .data_width_p   (DW),
        .vaddr_width_p  (VW),
        .csr_op_width_p (OW),
        .stages_p       (S),
        .num_fault_p    (NF),
        .fifo_els_p     (FE)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .cmd_v_i         (cmd_v),
        .cmd_op_i        (cmd_op),
        .cmd_addr_i      (cmd_addr),
        .cmd_data_i      (cmd_data),
        .kill_i          (kill),
        .fault_v_i       (fault_v),
        .fault_op_i      (fault_op),
        .fault_vaddr_i   (fault_vaddr),
        .csr_cmd_v_o     (csr_cmd_v),
        .csr_cmd_op_o    (csr_cmd_op),
        .csr_cmd_addr_o  (csr_cmd_addr),
        .csr_cmd_data_o  (csr_cmd_data),
        .csr_cmd_ready_i (csr_cmd_ready),
        .stall_o         (stall),
        .overflow_o      (overflow)
    );

    typedef struct {
        logic [OW-1:0] op;
        logic [11:0]   addr;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct {
        int   t;
        bit   dead;
        ent_t e;
    } pend_t;

    ent_t  exp_q[$];
    pend_t pend[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    m_cnt = 0;
    bit    m_ovf = 1'b0;
    bit    m_stall = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    // monitor: every handshake on the output pops the oldest expectation
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (reset_n && csr_cmd_v && csr_cmd_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out cycle %0d: got op %0h want none",
                             cyc, csr_cmd_op);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_op", 64'(csr_cmd_op), 64'(e.op));
                    chk("out_addr", 64'(csr_cmd_addr), 64'(e.addr));
                    chk("out_data", csr_cmd_data, e.data);
                end
            end
        end
    end

    task automatic step(input bit cv, input logic [OW-1:0] op,
                        input logic [11:0] ad, input logic [DW-1:0] dt,
                        input logic [S-1:0] kl, input logic [NF-1:0] fv,
                        input logic [NF*OW-1:0] fo, input logic [VW-1:0] va,
                        input bit rdy);
        ent_t  he;
        ent_t  ne;
        pend_t np;
        pend_t keep[$];
        bit    hv;
        bit    hlive;
        bit    enq;
        bit    deq;
        int    s;
        int    win;
        int    live;
        @(posedge clk);
        #1;
        cyc++;
        cmd_v = cv;
        cmd_op = op;
        cmd_addr = ad;
        cmd_data = dt;
        kill = kl;
        fault_v = fv;
        fault_op = fo;
        fault_vaddr = va;
        csr_cmd_ready = rdy;
        chk("stall", 64'(stall), 64'(m_stall));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("valid", 64'(csr_cmd_v), 64'(m_cnt != 0));
        hv = 1'b0;
        hlive = 1'b0;
        he = '{default: '0};
        foreach (pend[i]) begin
            s = cyc - 1 - pend[i].t;
            if (s == S - 1 && !pend[i].dead) begin
                hv = 1'b1;
                he = pend[i].e;
                hlive = !kl[s];
            end
            if (s >= 0 && s < S && kl[s]) pend[i].dead = 1'b1;
        end
        win = -1;
        for (int k = NF - 1; k >= 0; k--) if (fv[k]) win = k;
        enq = 1'b0;
        ne = '{default: '0};
        if (win >= 0) begin
            enq = 1'b1;
            ne.op = fo[win*OW +: OW];
            ne.addr = hv ? he.addr : 12'h0;
            ne.data = DW'(va);
        end else if (hv && hlive) begin
            enq = 1'b1;
            ne = he;
        end
        deq = (m_cnt > 0) && rdy;
        if (enq) begin
            if (m_cnt == FE && !deq) m_ovf = 1'b1;
            else begin
                exp_q.push_back(ne);
                m_cnt++;
            end
        end
        if (deq) m_cnt--;
        foreach (pend[i]) if (cyc - 1 - pend[i].t < S - 1) keep.push_back(pend[i]);
        pend = keep;
        if (cv) begin
            np.t = cyc;
            np.dead = 1'b0;
            np.e = '{op, ad, dt};
            pend.push_back(np);
        end
        live = 0;
        foreach (pend[i]) if (!pend[i].dead) live++;
        m_stall = (m_cnt + live) >= FE;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, '0, '0, '0, '0, '0, '0, '0, rdy);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        cmd_v = 1'b0;
        kill = '0;
        fault_v = '0;
        csr_cmd_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", 64'(csr_cmd_v), 64'd0);
        chk("rst_op", 64'(csr_cmd_op), 64'd0);
        chk("rst_addr", 64'(csr_cmd_addr), 64'd0);
        chk("rst_data", csr_cmd_data, 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        exp_q.delete();
        pend.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        m_stall = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [NF*OW-1:0] fo;
        logic [NF-1:0]    fv;
        logic [S-1:0]     kl;
        reset_n = 1'b0;
        cmd_v = 1'b0;
        cmd_op = '0;
        cmd_addr = '0;
        cmd_data = '0;
        kill = '0;
        fault_v = '0;
        fault_op = '0;
        fault_vaddr = '0;
        csr_cmd_ready = 1'b0;
        do_reset();

        step(1, 5'd5, 12'h300, 64'hA5, '0, '0, '0, '0, 1);
        idle(5, 1);

        step(1, 5'd7, 12'h301, 64'h1, '0, '0, '0, '0, 1);
        step(0, '0, '0, '0, 2'b01, '0, '0, '0, 1);
        idle(4, 1);

        fo = '0;
        fo[14:10] = 5'h1A;
        fo[29:25] = 5'h11;
        step(0, '0, '0, '0, '0, 8'b0010_0100, fo, 39'h7F_1234, 1);
        idle(3, 1);

        fo = '0;
        fo[4:0] = 5'h03;
        step(1, 5'd2, 12'h340, 64'h55, '0, '0, '0, '0, 1);
        idle(1, 1);
        step(0, '0, '0, '0, '0, 8'h01, fo, 39'h1000, 1);
        idle(3, 1);

        for (int i = 0; i < 10; i++)
            step(!m_stall, 5'(i), 12'(i), 64'($urandom), '0, '0, '0, '0, 0);
        fo = '0;
        fo[39:35] = 5'h1F;
        step(0, '0, '0, '0, '0, 8'h80, fo, 39'h42, 0);
        idle(3, 0);
        idle(8, 1);

        do_reset();
        for (int i = 0; i < 10; i++)
            step(!m_stall, 5'(i + 8), 12'(i + 16), 64'(i), '0, '0, '0, '0, 0);
        fo = '0;
        fo[9:5] = 5'h0C;
        step(0, '0, '0, '0, '0, 8'h02, fo, 39'h1_2345, 1);
        for (int i = 0; i < 10; i++) begin
            fo = {8{5'($urandom)}};
            step(!m_stall, 5'($urandom), 12'($urandom), 64'($urandom), '0,
                 (i % 3 == 0) ? 8'h08 : 8'h00, fo, 39'($urandom), 1);
        end
        idle(8, 1);

        for (int i = 0; i < 500; i++) begin
            if (i == 250) do_reset();
            kl = ($urandom % 8 == 0) ? S'($urandom) : '0;
            fv = ($urandom % 10 == 0) ? NF'($urandom) : '0;
            fo = {$urandom, $urandom};
            step(($urandom % 2 == 1) && !m_stall, 5'($urandom), 12'($urandom),
                 {$urandom, $urandom}, kl, fv, fo,
                 {7'($urandom), 32'($urandom)}, ($urandom % 3) != 0);
        end
        idle(12, 1);
        chk("drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
